bit_serial_add_seq: RTL and testbench
=====================================

# bit_serial_add_seq

Sequencer around a bit-serial add datapath. Accepts a pair of W-bit parallel operands over a valid/ready handshake, feeds them LSB-first through a one-bit full adder with a registered carry, and collects the serial sum into a parallel result returned over a second valid/ready handshake. Sits between parallel-word producers and consumers that want the area of a serial adder without handling bit sequencing, carry clearing or result assembly themselves.

## Interface
- W, default 8, operand/result width in bits; legal range 2..64.
- clk  input  1  clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-low reset.
- in_valid  input  1  operand pair presented.
- in_ready  output  1  block can accept an operand pair.
- a  input  W  operand A.
- b  input  W  operand B.
- sub  input  1  only with BSA_SUB_EN; 1 = compute a - b. Sampled with operands.
- out_valid  output  1  result held on sum/cout.
- out_ready  input  1  consumer takes result.
- sum  output  W  result word.
- cout  output  1  carry out of bit W-1.
- busy  output  1  high in SHIFT or DONE.

## Operation
- States: IDLE, SHIFT, DONE.
- IDLE: in_ready=1. On in_valid && in_ready: load a, b into shift registers; clear bit counter to 0; carry register := 0 (or the sub value, see Configuration); go to SHIFT.
- SHIFT: each cycle, s = a_sh[0] ^ b_eff ^ c, c_next = majority(a_sh[0], b_eff, c). s is shifted into the result register from the MSB end; a_sh and b_sh shift right by one. Counter increments. After the bit with counter = W-1: cout := c_next, go to DONE.
- DONE: out_valid=1; sum and cout stable. On out_ready: go to IDLE.
- The carry register is cleared at every operand load. No carry leaks between operations.
- Arithmetic is modulo 2^W. cout is the true carry out of the MSB.
- in_valid outside IDLE is ignored. a/b/sub are sampled only on the accept edge.
- Reset (reset low, any state, any time): state := IDLE, counter := 0, carry := 0, shift and result registers := 0. Any in-flight operation is discarded with no out_valid.
- Reset values: in_ready=1 (while reset deasserted in IDLE), out_valid=0, busy=0, sum=0, cout=0.

## Timing
- Accept edge E0 → SHIFT for exactly W cycles → out_valid rises at edge E0+W.
- Minimum accept-to-result latency: W cycles.
- Result held indefinitely while out_ready=0.
- DONE→IDLE on the edge where out_valid && out_ready. in_ready rises the following cycle; no same-cycle result-and-accept.
- Minimum throughput: one operation per W+2 cycles.
- in_ready, out_valid and busy are decoded from state only, with no combinational path from inputs.

## Configuration
- BSA_SUB_EN defined: sub port exists. On accept with sub=1, b_eff = ~b bit and carry := 1, so sum = a - b mod 2^W and cout=1 iff a >= b (unsigned). With sub=0, behaviour is identical to the add-only build.
- BSA_SUB_EN undefined: no sub port; b_eff = b bit; carry loads 0; add only.

## Test plan
- W=8, a=8'h5A, b=8'h33, out_ready=1 → out_valid exactly 8 cycles after accept; sum=8'h8D, cout=0; in_ready returns 1 cycle after output handshake.
- W=8, a=8'hFF, b=8'h01, then immediately a=8'h00, b=8'h00 → first result sum=8'h00, cout=1; second result sum=8'h00, cout=0, which proves the carry was cleared.
- Backpressure: out_ready=0 for 20 cycles after out_valid → sum/cout stable, out_valid stays high, and in_valid pulses during the wait are ignored; releasing out_ready returns the block to IDLE.
- Reset low at bit 4 of a=8'hF0 + b=8'h0F → all outputs go to reset values immediately; out_valid never asserts; the next operation 8'h01+8'h01 gives 8'h02.
- BSA_SUB_EN: a=8'h10, b=8'h01, sub=1 → sum=8'h0F, cout=1. a=8'h01, b=8'h02, sub=1 → sum=8'hFF, cout=0.
- W=2 corner: a=2'b11, b=2'b11 → sum=2'b10, cout=1, out_valid 2 cycles after accept.

Source files
------------

// File: rtl/bit_serial_add_seq_if.sv
// Operand/result handshake bundle for bit_serial_add_seq.
// The sub signal exists only when BSA_SUB_EN is defined.
interface bit_serial_add_seq_if #(
    parameter int unsigned W = 8
);
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
`ifdef BSA_SUB_EN
    logic         sub;
`endif
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] sum;
    logic         cout;
    logic         busy;

    // Producer/consumer side
    modport master (
        output in_valid, a, b,
`ifdef BSA_SUB_EN
        output sub,
`endif
        output out_ready,
        input  in_ready, out_valid, sum, cout, busy
    );

    // Adder sequencer side
    modport slave (
        input  in_valid, a, b,
`ifdef BSA_SUB_EN
        input  sub,
`endif
        input  out_ready,
        output in_ready, out_valid, sum, cout, busy
    );
endinterface

// File: rtl/bit_serial_add_seq.sv
// Bit-serial adder sequencer: parallel operands in, LSB-first full-add, parallel sum out.
// Define BSA_SUB_EN to add the sub input (a - b via inverted b and carry-in of 1).
module bit_serial_add_seq #(
    parameter int unsigned W = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    bit_serial_add_seq_if.slave  bus
);
    localparam int unsigned CNT_W = $clog2(W);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_SHIFT = 2'd1;
    localparam logic [1:0] S_DONE  = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [W-1:0]     a_sh_q, a_sh_d;
    logic [W-1:0]     b_sh_q, b_sh_d;
    logic [W-1:0]     res_q, res_d;
    logic             c_q, c_d;
    logic             cout_q, cout_d;
    logic             in_ready_q, in_ready_d;
    logic             out_valid_q, out_valid_d;
    logic             busy_q, busy_d;
    logic             b_eff, s_bit, c_next;
`ifdef BSA_SUB_EN
    logic             sub_q, sub_d;
`endif

    // One-bit full adder on the current LSBs
`ifdef BSA_SUB_EN
    assign b_eff = b_sh_q[0] ^ sub_q;
`else
    assign b_eff = b_sh_q[0];
`endif
    assign s_bit  = a_sh_q[0] ^ b_eff ^ c_q;
    assign c_next = (a_sh_q[0] & b_eff) | (a_sh_q[0] & c_q) | (b_eff & c_q);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        a_sh_d  = a_sh_q;
        b_sh_d  = b_sh_q;
        res_d   = res_q;
        c_d     = c_q;
        cout_d  = cout_q;
`ifdef BSA_SUB_EN
        sub_d   = sub_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (bus.in_valid) begin
                    a_sh_d  = bus.a;
                    b_sh_d  = bus.b;
                    res_d   = '0;
                    cnt_d   = '0;
                    cout_d  = 1'b0;
`ifdef BSA_SUB_EN
                    sub_d   = bus.sub;
                    c_d     = bus.sub;
`else
                    c_d     = 1'b0;
`endif
                    state_d = S_SHIFT;
                end
            end
            S_SHIFT: begin
                // Sum bits enter at the MSB so bit 0 lands in place after W shifts
                res_d  = {s_bit, res_q[W-1:1]};
                a_sh_d = {1'b0, a_sh_q[W-1:1]};
                b_sh_d = {1'b0, b_sh_q[W-1:1]};
                c_d    = c_next;
                cnt_d  = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(W - 1)) begin
                    cout_d  = c_next;
                    cnt_d   = '0;
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                if (bus.out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Handshake flags follow the next state so they come straight from flops
        in_ready_d  = (state_d == S_IDLE);
        out_valid_d = (state_d == S_DONE);
        busy_d      = (state_d == S_SHIFT) || (state_d == S_DONE);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            a_sh_q      <= '0;
            b_sh_q      <= '0;
            res_q       <= '0;
            c_q         <= 1'b0;
            cout_q      <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
`ifdef BSA_SUB_EN
            sub_q       <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            a_sh_q      <= a_sh_d;
            b_sh_q      <= b_sh_d;
            res_q       <= res_d;
            c_q         <= c_d;
            cout_q      <= cout_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
`ifdef BSA_SUB_EN
            sub_q       <= sub_d;
`endif
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.busy      = busy_q;
    assign bus.sum       = res_q;
    assign bus.cout      = cout_q;
endmodule

// File: tb/tb_bit_serial_add_seq.sv
// Directed self-checking bench for bit_serial_add_seq (W=8 and W=2 instances).
module tb_bit_serial_add_seq;
    logic clk;
    logic reset;
    int   n_checks;
    int   n_fail;

    bit_serial_add_seq_if #(.W(8)) bus8 ();
    bit_serial_add_seq_if #(.W(2)) bus2 ();

    bit_serial_add_seq #(.W(8)) u_dut8 (.clk(clk), .reset(reset), .bus(bus8));
    bit_serial_add_seq #(.W(2)) u_dut2 (.clk(clk), .reset(reset), .bus(bus2));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Present one operand pair at a falling edge; returns one falling edge after the accept edge
    task automatic launch8(input logic [7:0] ta, input logic [7:0] tbv, input logic ts);
        n_checks++;
        if (bus8.in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL launch_in_ready: got %b expected 1", bus8.in_ready);
        end
        bus8.a        = ta;
        bus8.b        = tbv;
`ifdef BSA_SUB_EN
        bus8.sub      = ts;
`else
        if (ts) $display("note: sub ignored in add-only build");
`endif
        bus8.in_valid = 1'b1;
        @(negedge clk);
        bus8.in_valid = 1'b0;
    endtask

    task automatic wait_out8(output int cycles);
        cycles = 0;
        while (bus8.out_valid !== 1'b1 && cycles < 100) begin
            @(negedge clk);
            cycles++;
        end
    endtask

    task automatic test_reset();
        n_checks += 5;
        if (bus8.in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b expected 1", bus8.in_ready); end
        if (bus8.out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b expected 0", bus8.out_valid); end
        if (bus8.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", bus8.busy); end
        if (bus8.sum !== 8'h00) begin n_fail++; $display("FAIL reset_sum: got %h expected 00", bus8.sum); end
        if (bus8.cout !== 1'b0) begin n_fail++; $display("FAIL reset_cout: got %b expected 0", bus8.cout); end
    endtask

    task automatic test_basic();
        int cyc;
        bus8.out_ready = 1'b1;
        launch8(8'h5A, 8'h33, 1'b0);
        n_checks += 2;
        if (bus8.busy !== 1'b1) begin n_fail++; $display("FAIL basic_busy: got %b expected 1", bus8.busy); end
        if (bus8.in_ready !== 1'b0) begin n_fail++; $display("FAIL basic_in_ready_low: got %b expected 0", bus8.in_ready); end
        wait_out8(cyc);
        n_checks += 4;
        if (cyc !== 8) begin n_fail++; $display("FAIL basic_latency: got %0d expected 8", cyc); end
        if (bus8.sum !== 8'h8D) begin n_fail++; $display("FAIL basic_sum: got %h expected 8d", bus8.sum); end
        if (bus8.cout !== 1'b0) begin n_fail++; $display("FAIL basic_cout: got %b expected 0", bus8.cout); end
        if (bus8.in_ready !== 1'b0) begin n_fail++; $display("FAIL basic_no_same_cycle_accept: got %b expected 0", bus8.in_ready); end
        @(negedge clk);
        n_checks += 3;
        if (bus8.out_valid !== 1'b0) begin n_fail++; $display("FAIL basic_out_valid_drop: got %b expected 0", bus8.out_valid); end
        if (bus8.in_ready !== 1'b1) begin n_fail++; $display("FAIL basic_in_ready_return: got %b expected 1", bus8.in_ready); end
        if (bus8.busy !== 1'b0) begin n_fail++; $display("FAIL basic_busy_clear: got %b expected 0", bus8.busy); end
    endtask

    task automatic test_back_to_back();
        int cyc;
        bus8.out_ready = 1'b1;
        launch8(8'hFF, 8'h01, 1'b0);
        wait_out8(cyc);
        n_checks += 3;
        if (cyc !== 8) begin n_fail++; $display("FAIL b2b_latency1: got %0d expected 8", cyc); end
        if (bus8.sum !== 8'h00) begin n_fail++; $display("FAIL b2b_sum1: got %h expected 00", bus8.sum); end
        if (bus8.cout !== 1'b1) begin n_fail++; $display("FAIL b2b_cout1: got %b expected 1", bus8.cout); end
        @(negedge clk);
        launch8(8'h00, 8'h00, 1'b0);
        wait_out8(cyc);
        n_checks += 3;
        if (cyc !== 8) begin n_fail++; $display("FAIL b2b_latency2: got %0d expected 8", cyc); end
        if (bus8.sum !== 8'h00) begin n_fail++; $display("FAIL b2b_sum2: got %h expected 00", bus8.sum); end
        if (bus8.cout !== 1'b0) begin n_fail++; $display("FAIL b2b_cout2_carry_leak: got %b expected 0", bus8.cout); end
        @(negedge clk);
    endtask

    task automatic test_backpressure();
        int cyc;
        bus8.out_ready = 1'b0;
        launch8(8'hC8, 8'h64, 1'b0);
        wait_out8(cyc);
        n_checks++;
        if (cyc !== 8) begin n_fail++; $display("FAIL bp_latency: got %0d expected 8", cyc); end
        for (int i = 0; i < 20; i++) begin
            bus8.a        = 8'hAA;
            bus8.b        = 8'h55;
            bus8.in_valid = i[0];
            @(negedge clk);
            n_checks += 4;
            if (bus8.out_valid !== 1'b1) begin n_fail++; $display("FAIL bp_out_valid cycle %0d: got %b expected 1", i, bus8.out_valid); end
            if (bus8.sum !== 8'h2C) begin n_fail++; $display("FAIL bp_sum cycle %0d: got %h expected 2c", i, bus8.sum); end
            if (bus8.cout !== 1'b1) begin n_fail++; $display("FAIL bp_cout cycle %0d: got %b expected 1", i, bus8.cout); end
            if (bus8.in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_in_ready cycle %0d: got %b expected 0", i, bus8.in_ready); end
        end
        bus8.in_valid  = 1'b0;
        bus8.out_ready = 1'b1;
        @(negedge clk);
        n_checks += 3;
        if (bus8.out_valid !== 1'b0) begin n_fail++; $display("FAIL bp_release_out_valid: got %b expected 0", bus8.out_valid); end
        if (bus8.in_ready !== 1'b1) begin n_fail++; $display("FAIL bp_release_in_ready: got %b expected 1", bus8.in_ready); end
        if (bus8.busy !== 1'b0) begin n_fail++; $display("FAIL bp_release_busy: got %b expected 0", bus8.busy); end
        @(negedge clk);
        n_checks++;
        if (bus8.busy !== 1'b0) begin n_fail++; $display("FAIL bp_ignored_pulse_started_op: got %b expected 0", bus8.busy); end
    endtask

    task automatic test_reset_midop();
        int cyc;
        logic seen;
        bus8.out_ready = 1'b1;
        launch8(8'hF0, 8'h0F, 1'b0);
        repeat (3) @(negedge clk);
        reset = 1'b0;
        #1;
        n_checks += 4;
        if (bus8.out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_mid_out_valid: got %b expected 0", bus8.out_valid); end
        if (bus8.busy !== 1'b0) begin n_fail++; $display("FAIL rst_mid_busy: got %b expected 0", bus8.busy); end
        if (bus8.sum !== 8'h00) begin n_fail++; $display("FAIL rst_mid_sum: got %h expected 00", bus8.sum); end
        if (bus8.cout !== 1'b0) begin n_fail++; $display("FAIL rst_mid_cout: got %b expected 0", bus8.cout); end
        repeat (2) @(negedge clk);
        reset = 1'b1;
        seen  = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (bus8.out_valid === 1'b1) seen = 1'b1;
        end
        n_checks += 2;
        if (seen !== 1'b0) begin n_fail++; $display("FAIL rst_mid_ghost_out_valid: got %b expected 0", seen); end
        if (bus8.in_ready !== 1'b1) begin n_fail++; $display("FAIL rst_mid_in_ready: got %b expected 1", bus8.in_ready); end
        launch8(8'h01, 8'h01, 1'b0);
        wait_out8(cyc);
        n_checks += 3;
        if (cyc !== 8) begin n_fail++; $display("FAIL rst_after_latency: got %0d expected 8", cyc); end
        if (bus8.sum !== 8'h02) begin n_fail++; $display("FAIL rst_after_sum: got %h expected 02", bus8.sum); end
        if (bus8.cout !== 1'b0) begin n_fail++; $display("FAIL rst_after_cout: got %b expected 0", bus8.cout); end
        @(negedge clk);
    endtask

`ifdef BSA_SUB_EN
    task automatic test_sub();
        int cyc;
        bus8.out_ready = 1'b1;
        launch8(8'h10, 8'h01, 1'b1);
        wait_out8(cyc);
        n_checks += 3;
        if (cyc !== 8) begin n_fail++; $display("FAIL sub1_latency: got %0d expected 8", cyc); end
        if (bus8.sum !== 8'h0F) begin n_fail++; $display("FAIL sub1_sum: got %h expected 0f", bus8.sum); end
        if (bus8.cout !== 1'b1) begin n_fail++; $display("FAIL sub1_cout: got %b expected 1", bus8.cout); end
        @(negedge clk);
        launch8(8'h01, 8'h02, 1'b1);
        wait_out8(cyc);
        n_checks += 2;
        if (bus8.sum !== 8'hFF) begin n_fail++; $display("FAIL sub2_sum: got %h expected ff", bus8.sum); end
        if (bus8.cout !== 1'b0) begin n_fail++; $display("FAIL sub2_cout: got %b expected 0", bus8.cout); end
        @(negedge clk);
        bus8.sub = 1'b0;
    endtask
`endif

    task automatic test_w2();
        int cyc;
        bus2.out_ready = 1'b1;
        n_checks++;
        if (bus2.in_ready !== 1'b1) begin n_fail++; $display("FAIL w2_in_ready: got %b expected 1", bus2.in_ready); end
        bus2.a        = 2'b11;
        bus2.b        = 2'b11;
        bus2.in_valid = 1'b1;
        @(negedge clk);
        bus2.in_valid = 1'b0;
        cyc = 0;
        while (bus2.out_valid !== 1'b1 && cyc < 100) begin
            @(negedge clk);
            cyc++;
        end
        n_checks += 3;
        if (cyc !== 2) begin n_fail++; $display("FAIL w2_latency: got %0d expected 2", cyc); end
        if (bus2.sum !== 2'b10) begin n_fail++; $display("FAIL w2_sum: got %b expected 10", bus2.sum); end
        if (bus2.cout !== 1'b1) begin n_fail++; $display("FAIL w2_cout: got %b expected 1", bus2.cout); end
        @(negedge clk);
    endtask

    initial begin
        n_checks       = 0;
        n_fail         = 0;
        reset          = 1'b0;
        bus8.in_valid  = 1'b0;
        bus8.a         = '0;
        bus8.b         = '0;
        bus8.out_ready = 1'b1;
        bus2.in_valid  = 1'b0;
        bus2.a         = '0;
        bus2.b         = '0;
        bus2.out_ready = 1'b1;
`ifdef BSA_SUB_EN
        bus8.sub       = 1'b0;
        bus2.sub       = 1'b0;
`endif
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);

        test_reset();
        test_basic();
        test_back_to_back();
        test_backpressure();
        test_reset_midop();
`ifdef BSA_SUB_EN
        test_sub();
`endif
        test_w2();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
